// File: rtl/param_accum_proc.sv
// rtl/param_accum_proc.sv - parametrised A/B accumulator processor with load phase and on-chip memory
//
// Load phase: with load_en high, the first load_valid word sets the base
// address and each later word is written to mem[pc], pc auto-incrementing.
// Run phase: start launches execution at start_pc; every instruction is an
// opcode word followed by an operand word and takes FETCH, OPERAND, EXEC.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   load_en, load_valid load-phase enable and word qualifier
//   load_data [DW]      base address first, then memory contents
//   start, start_pc     run request pulse and first instruction address
//   busy, halted, err   status: loading/running, in HALT, sticky illegal opcode
//   out_valid, out_data one-cycle pulse carrying A captured by OUT
//   acc_a, flag_z, flag_c  A register and zero / carry-borrow flags
module param_accum_proc #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  input  logic [AW-1:0] start_pc,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [DW-1:0] acc_a,
  output logic          flag_z,
  output logic          flag_c
);

  localparam int DEPTH = 1 << AW;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_ADDR = 3'd1;
  localparam logic [2:0] S_LOAD_DATA = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_OPERAND   = 3'd4;
  localparam logic [2:0] S_EXEC      = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;
  localparam logic [3:0] OP_LDAM = 4'h9;
  localparam logic [3:0] OP_LDBM = 4'hA;
  localparam logic [3:0] OP_STA  = 4'hC;

  logic [DW-1:0] mem_q [DEPTH];

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] arg_q, arg_d;
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          z_q, z_d;
  logic          c_q, c_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic [AW-1:0] arg_addr;
  logic [DW-1:0] rd_pc;
  logic [DW-1:0] rd_arg;
  logic [DW:0]   sum;
  logic [DW:0]   diff;

  assign arg_addr = arg_q[AW-1:0];
  // Reads are combinational so a STA landing on a later fetch address is
  // seen by that fetch (self-modifying code).
  assign rd_pc    = mem_q[pc_q];
  assign rd_arg   = mem_q[arg_addr];
  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  // The extra top bit of a zero-extended subtraction is the borrow (A < B).
  assign diff     = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    arg_d       = arg_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    z_d         = z_q;
    c_d         = c_q;
    mem_we      = 1'b0;
    mem_waddr   = pc_q;
    mem_wdata   = load_data;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (load_en) begin
          state_d = S_LOAD_ADDR;
          err_d   = 1'b0;
        end else if (start) begin
          pc_d    = start_pc;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_LOAD_ADDR: begin
        if (!load_en) begin
          state_d = S_IDLE;
        end else if (load_valid) begin
          pc_d    = load_data[AW-1:0];
          state_d = S_LOAD_DATA;
        end
      end
      S_LOAD_DATA: begin
        if (!load_en) begin
          state_d = S_IDLE;
        end else if (load_valid) begin
          mem_we = 1'b1;
          pc_d   = pc_q + AW'(1);
        end
      end
      S_FETCH: begin
        op_d    = rd_pc[3:0];
        pc_d    = pc_q + AW'(1);
        state_d = S_OPERAND;
      end
      S_OPERAND: begin
        arg_d   = rd_pc;
        pc_d    = pc_q + AW'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_NOP: ;
          OP_LDA: begin
            a_d = arg_q;
            z_d = (arg_q == '0);
          end
          OP_LDB: b_d = arg_q;
          OP_ADD: begin
            {c_d, a_d} = sum;
            z_d        = (sum[DW-1:0] == '0);
          end
          OP_JMP: pc_d = arg_addr;
          OP_JZ: begin
            if (z_q) pc_d = arg_addr;
          end
          OP_SUB: begin
            a_d = diff[DW-1:0];
            c_d = diff[DW];
            z_d = (diff[DW-1:0] == '0);
          end
          OP_OUT: begin
            out_data_d  = a_q;
            out_valid_d = 1'b1;
          end
          OP_HALT: state_d = S_HALT;
          OP_LDAM: begin
            a_d = rd_arg;
            z_d = (rd_arg == '0);
          end
          OP_LDBM: b_d = rd_arg;
          OP_STA: begin
            mem_we    = 1'b1;
            mem_waddr = arg_addr;
            mem_wdata = a_q;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      arg_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      z_q         <= z_d;
      c_q         <= c_d;
    end
  end

  // Memory contents survive reset; only the write port is gated.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign busy      = (state_q == S_LOAD_ADDR) || (state_q == S_LOAD_DATA) ||
                     (state_q == S_FETCH) || (state_q == S_OPERAND) ||
                     (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign acc_a     = a_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;

endmodule

// File: tb/tb_param_accum_proc.sv
// tb/tb_param_accum_proc.sv - self-checking bench for param_accum_proc against an ISA-level model
module tb_param_accum_proc;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en, load_valid, start;
  logic [7:0] load_data, start_pc;
  logic       busy, halted, err, out_valid, flag_z, flag_c;
  logic [7:0] out_data, acc_a;

  int vectors = 0;
  int miscompares = 0;

  param_accum_proc #(.DW(8), .AW(8)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid),
    .load_data(load_data), .start(start), .start_pc(start_pc),
    .busy(busy), .halted(halted), .err(err), .out_valid(out_valid),
    .out_data(out_data), .acc_a(acc_a), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // Reference machine: memory image plus architectural registers.
  logic [7:0] ref_mem [256];
  logic [7:0] m_a, m_b;
  logic       m_z, m_c, m_err;
  int         exp_cycles;
  logic [7:0] exp_outs[$];

  int         obs_cycles;
  logic       obs_err0;
  logic [7:0] obs_outs[$];
  logic [7:0] ld_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic w(input logic [7:0] x);
    ld_q.push_back(x);
  endtask

  task automatic ins(input logic [7:0] op, input logic [7:0] arg);
    ld_q.push_back(op);
    ld_q.push_back(arg);
  endtask

  task automatic model_reset;
    m_a = 8'h00; m_b = 8'h00; m_z = 1'b0; m_c = 1'b0; m_err = 1'b0;
  endtask

  // Loads ld_q at base with random idle gaps and stray start pulses.
  task automatic load_block(input logic [7:0] base);
    logic [7:0] a;
    a = base;
    load_en = 1'b1; load_valid = 1'b0; start = 1'($urandom_range(0, 1));
    start_pc = 8'($urandom);
    tick;
    load_valid = 1'b1; load_data = base; start = 1'b0;
    tick;
    foreach (ld_q[i]) begin
      while ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0; load_data = 8'($urandom); start = 1'($urandom_range(0, 1));
        tick;
      end
      load_valid = 1'b1; load_data = ld_q[i]; start = 1'b0;
      tick;
      ref_mem[a] = ld_q[i];
      a = a + 8'd1;
    end
    load_valid = 1'b0; load_en = 1'b0; start = 1'b0;
    tick;
    ld_q.delete();
  endtask

  // Instruction-level interpreter: whole instructions, 3 cycles each.
  task automatic model_run(input logic [7:0] spc);
    logic [7:0] pc, pc1, op, arg;
    logic [8:0] s;
    int n;
    bit done;
    pc = spc; m_err = 1'b0; exp_outs.delete(); n = 0; done = 0;
    while (!done && n < 600) begin
      pc1 = pc + 8'd1;
      op = ref_mem[pc]; arg = ref_mem[pc1];
      pc = pc + 8'd2;
      n++;
      case (op & 8'h0F)
        8'h0: ;
        8'h1: begin m_a = arg; m_z = (m_a == 0); end
        8'h2: m_b = arg;
        8'h3: begin s = {1'b0, m_a} + {1'b0, m_b}; m_a = s[7:0]; m_c = s[8]; m_z = (m_a == 0); end
        8'h4: pc = arg;
        8'h5: if (m_z) pc = arg;
        8'h6: begin m_c = (m_a < m_b); m_a = m_a - m_b; m_z = (m_a == 0); end
        8'h7: exp_outs.push_back(m_a);
        8'h8: done = 1;
        8'h9: begin m_a = ref_mem[arg]; m_z = (m_a == 0); end
        8'hA: m_b = ref_mem[arg];
        8'hC: ref_mem[arg] = m_a;
        default: begin m_err = 1'b1; done = 1; end
      endcase
    end
    exp_cycles = 3 * n;
  endtask

  // Starts the DUT and counts cycles until halted; optionally jiggles
  // start/load_en mid-run, which the DUT must ignore.
  task automatic dut_run(input logic [7:0] spc, input bit noise);
    start = 1'b1; start_pc = spc;
    tick;
    start = 1'b0;
    obs_err0 = err;
    obs_cycles = 0; obs_outs.delete();
    while (halted !== 1'b1 && obs_cycles < 2000) begin
      if (out_valid === 1'b1) obs_outs.push_back(out_data);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        load_en = ($urandom_range(0, 3) == 0);
        start_pc = 8'($urandom);
      end
      tick;
      obs_cycles++;
    end
    start = 1'b0; load_en = 1'b0;
  endtask

  function automatic bit outs_match();
    if (obs_outs.size() != exp_outs.size()) return 0;
    foreach (exp_outs[i]) if (obs_outs[i] !== exp_outs[i]) return 0;
    return 1;
  endfunction

  task automatic test_reset;
    rst = 1'b0; load_en = 0; load_valid = 0; load_data = 0; start = 0; start_pc = 0;
    tick; tick;
    vectors++;
    if ({acc_a, out_data, busy, halted, err, out_valid, flag_z, flag_c} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got acc=%h out=%h busy=%b halted=%b err=%b ov=%b z=%b c=%b, want all 0",
               acc_a, out_data, busy, halted, err, out_valid, flag_z, flag_c);
    end
    rst = 1'b1;
    tick;
    model_reset();
  endtask

  task automatic test_add_out;
    ins(8'h01, 8'h05); ins(8'h02, 8'h03); ins(8'h03, 8'h00); ins(8'h07, 8'h00); ins(8'h08, 8'h00);
    load_block(8'h10);
    model_run(8'h10); dut_run(8'h10, 0);
    vectors++;
    if (obs_cycles !== 15) begin
      miscompares++; $display("FAIL add_halt_latency: got %0d cycles, want 15", obs_cycles);
    end
    vectors++;
    if ({acc_a, flag_z, flag_c, err, halted} !== {m_a, m_z, m_c, m_err, 1'b1}) begin
      miscompares++;
      $display("FAIL add_state: got a=%h z=%b c=%b err=%b h=%b, want a=%h z=%b c=%b err=%b h=1",
               acc_a, flag_z, flag_c, err, halted, m_a, m_z, m_c, m_err);
    end
    vectors++;
    if (!outs_match()) begin
      miscompares++; $display("FAIL add_out: got %0d pulses, want %0d (value %h)",
                              obs_outs.size(), exp_outs.size(), m_a);
    end
  endtask

  task automatic test_sub;
    ins(8'h01, 8'h02); ins(8'h02, 8'h03); ins(8'h06, 8'h00); ins(8'h08, 8'h00);
    ins(8'h01, 8'h03); ins(8'h02, 8'h03); ins(8'h06, 8'h00); ins(8'h08, 8'h00);
    load_block(8'h70);
    for (int k = 0; k < 2; k++) begin
      model_run(8'h70 + 8'(8 * k)); dut_run(8'h70 + 8'(8 * k), 1);
      vectors++;
      if ({acc_a, flag_z, flag_c, err, halted} !== {m_a, m_z, m_c, m_err, 1'b1}) begin
        miscompares++;
        $display("FAIL sub_%0d: got a=%h z=%b c=%b err=%b h=%b, want a=%h z=%b c=%b err=%b h=1",
                 k, acc_a, flag_z, flag_c, err, halted, m_a, m_z, m_c, m_err);
      end
      vectors++;
      if (obs_cycles !== exp_cycles) begin
        miscompares++; $display("FAIL sub_%0d_cycles: got %0d, want %0d", k, obs_cycles, exp_cycles);
      end
    end
  endtask

  task automatic test_branch_store;
    logic [7:0] r;
    ins(8'h08, 8'h00);
    load_block(8'h20);
    ins(8'h01, 8'h00); ins(8'h05, 8'h20); ins(8'h07, 8'h00); ins(8'h08, 8'h00);
    load_block(8'h60);
    model_run(8'h60); dut_run(8'h60, 0);
    vectors++;
    if (obs_cycles !== exp_cycles || !outs_match()) begin
      miscompares++;
      $display("FAIL jz_taken: got %0d cycles %0d pulses, want %0d cycles %0d pulses",
               obs_cycles, obs_outs.size(), exp_cycles, exp_outs.size());
    end
    r = 8'($urandom_range(1, 255));
    ins(8'h01, r); ins(8'h0C, 8'hE0); ins(8'h01, 8'h00); ins(8'h0A, 8'hE0);
    ins(8'h03, 8'h00); ins(8'h07, 8'h00); ins(8'h08, 8'h00);
    load_block(8'hB0);
    model_run(8'hB0); dut_run(8'hB0, 1);
    vectors++;
    if (!outs_match() || acc_a !== m_a) begin
      miscompares++;
      $display("FAIL sta_ldbm: got acc=%h pulses=%0d, want acc=%h pulses=%0d (stored %h)",
               acc_a, obs_outs.size(), m_a, exp_outs.size(), r);
    end
  endtask

  task automatic test_load_wrap;
    w(8'h11); w(8'h11); w(8'h11); w(8'h11); w(8'h5A);
    load_block(8'hFE);
    for (int i = 0; i < 4; i++) w(8'($urandom));
    load_block(8'hFE);
    ins(8'h09, 8'hFE); ins(8'h07, 0); ins(8'h09, 8'hFF); ins(8'h07, 0);
    ins(8'h09, 8'h00); ins(8'h07, 0); ins(8'h09, 8'h01); ins(8'h07, 0);
    ins(8'h09, 8'h02); ins(8'h07, 0); ins(8'h08, 0);
    load_block(8'h30);
    model_run(8'h30); dut_run(8'h30, 0);
    vectors++;
    if (!outs_match()) begin
      miscompares++;
      $display("FAIL load_wrap: got %0d pulses, want %0d; last got %h want %h",
               obs_outs.size(), exp_outs.size(),
               (obs_outs.size() > 0) ? obs_outs[$] : 8'hxx, exp_outs[$]);
    end
  endtask

  task automatic test_illegal;
    ins(8'h0B, 8'h00);
    load_block(8'h50);
    model_run(8'h50); dut_run(8'h50, 0);
    vectors++;
    if (err !== 1'b1 || halted !== 1'b1 || obs_cycles !== 3) begin
      miscompares++;
      $display("FAIL illegal_op: got err=%b halted=%b cycles=%0d, want err=1 halted=1 cycles=3",
               err, halted, obs_cycles);
    end
    model_run(8'h10); dut_run(8'h10, 0);
    vectors++;
    if (obs_err0 !== 1'b0 || err !== m_err) begin
      miscompares++;
      $display("FAIL err_clear: got err after start=%b at end=%b, want 0 and %b", obs_err0, err, m_err);
    end
  endtask

  task automatic test_reset_mid_run;
    start = 1'b1; start_pc = 8'h10;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    vectors++;
    if (acc_a !== 8'h05 || busy !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset: got acc=%h busy=%b, want acc=05 busy=1", acc_a, busy);
    end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    model_reset();
    vectors++;
    if ({acc_a, busy, halted, flag_c, flag_z, out_valid} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_in_exec: got acc=%h busy=%b halted=%b c=%b z=%b ov=%b, want all 0",
               acc_a, busy, halted, flag_c, flag_z, out_valid);
    end
    model_run(8'h10); dut_run(8'h10, 0);
    vectors++;
    if (acc_a !== m_a || !outs_match() || obs_cycles !== exp_cycles) begin
      miscompares++;
      $display("FAIL rerun_after_reset: got acc=%h pulses=%0d cycles=%0d, want acc=%h pulses=%0d cycles=%0d",
               acc_a, obs_outs.size(), obs_cycles, m_a, exp_outs.size(), exp_cycles);
    end
  endtask

  task automatic test_load_priority;
    load_en = 1'b1; start = 1'b1; start_pc = 8'h10; load_valid = 1'b0;
    tick;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || halted !== 1'b0) begin
      miscompares++; $display("FAIL load_vs_start: got busy=%b halted=%b, want 1 0", busy, halted);
    end
    load_en = 1'b0;
    tick;
    vectors++;
    if (busy !== 1'b0 || halted !== 1'b0) begin
      miscompares++; $display("FAIL load_exit_idle: got busy=%b halted=%b, want 0 0", busy, halted);
    end
  endtask

  task automatic test_random;
    logic [7:0] ops [10] = '{8'h0, 8'h1, 8'h2, 8'h3, 8'h6, 8'h7, 8'h9, 8'hA, 8'hC, 8'h5};
    logic [7:0] op, arg, halt_at;
    int n;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 8; i++) w(8'($urandom));
      load_block(8'hC0);
      n = $urandom_range(4, 10);
      halt_at = 8'h90 + 8'(2 * n);
      for (int i = 0; i < n; i++) begin
        op = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 29) == 0) op = 8'($urandom_range(13, 15));
        if ($urandom_range(0, 19) == 0) op = 8'h4;
        if (op == 8'h9 || op == 8'hA || op == 8'hC) arg = 8'hC0 + 8'($urandom_range(0, 7));
        else if (op == 8'h4 || op == 8'h5) arg = halt_at;
        else arg = 8'($urandom);
        ins({4'($urandom), op[3:0]}, arg);
      end
      ins(8'h08, 8'h00);
      load_block(8'h90);
      model_run(8'h90); dut_run(8'h90, 1);
      vectors++;
      if ({acc_a, flag_z, flag_c, err, halted} !== {m_a, m_z, m_c, m_err, 1'b1}) begin
        miscompares++;
        $display("FAIL rand_%0d_state: got a=%h z=%b c=%b err=%b h=%b, want a=%h z=%b c=%b err=%b h=1",
                 it, acc_a, flag_z, flag_c, err, halted, m_a, m_z, m_c, m_err);
      end
      vectors++;
      if (obs_cycles !== exp_cycles || !outs_match()) begin
        miscompares++;
        $display("FAIL rand_%0d_trace: got %0d cycles %0d pulses, want %0d cycles %0d pulses",
                 it, obs_cycles, obs_outs.size(), exp_cycles, exp_outs.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_out();
    test_sub();
    test_branch_store();
    test_load_wrap();
    test_illegal();
    test_reset_mid_run();
    test_load_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_accum_proc.md
Name: param_accum_proc

Overview:
- Parametrised two-register (A/B) accumulator processor with on-chip program/data memory.
- Two phases: a serial load phase writes a base address and then sequential words into memory; a run phase executes from a given start PC until HALT or an illegal opcode.
- Adds configurable width and depth, branching, store-to-memory, flags, an output port and error reporting.
- Sits between the host byte/word stream and downstream logic that consumes out_data.

Parameters:
- DW, 8, data/instruction word width (>=8)
- AW, 8, address width; memory depth = 2**AW words

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- load_en  in  1  load-phase enable (level)
- load_valid  in  1  load_data qualifier
- load_data  in  DW  first valid word = base address (low AW bits); later words = memory contents
- start  in  1  run request (pulse)
- start_pc  in  AW  first instruction address, sampled with start
- busy  out  1  high in LOAD_ADDR, LOAD_DATA, FETCH, OPERAND, EXEC
- halted  out  1  high in HALT state
- err  out  1  sticky illegal-opcode flag
- out_valid  out  1  one-cycle pulse on OUT
- out_data  out  DW  A value captured by OUT
- acc_a  out  DW  current A register
- flag_z, flag_c  out  1  zero / carry-borrow flags

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, A=B=PC=0, opcode/operand regs=0, busy=halted=err=out_valid=flag_z=flag_c=0, out_data=0. Memory is not cleared. Reset has priority in every state, including mid-run and mid-load.
- States: IDLE, LOAD_ADDR, LOAD_DATA, FETCH, OPERAND, EXEC, HALT.
- IDLE/HALT:
  - load_en=1 -> LOAD_ADDR; err cleared.
  - Else start=1 -> PC<=start_pc, err<=0, go to FETCH.
  - load_en wins over simultaneous start.
- LOAD_ADDR: on load_valid, PC<=load_data[AW-1:0] -> LOAD_DATA.
- LOAD_DATA: on load_valid, mem[PC]<=load_data and PC<=PC+1; PC wraps 2**AW-1 -> 0.
- Load exit: load_en=0 in either load state -> IDLE. start is ignored while loading.
- Instruction format: two words. Word 0 = opcode in bits[3:0] (upper bits ignored); word 1 = operand (immediate, or address using low AW bits).
- Instruction cycle:
  - FETCH: op<=mem[PC], PC+1.
  - OPERAND: arg<=mem[PC], PC+1.
  - EXEC: execute, then FETCH (or HALT).
  - Exactly 3 cycles per instruction. Memory read is combinational from the array register. PC wraps modulo 2**AW.
- Opcodes:
  - 0 NOP
  - 1 LDA: A<=arg; Z updated
  - 2 LDB: B<=arg
  - 3 ADD: {C,A}<=A+B (DW+1 bits); Z updated
  - 4 JMP: PC<=arg
  - 5 JZ: if flag_z, PC<=arg
  - 6 SUB: A<=A-B mod 2**DW; C=1 on borrow (A<B); Z updated
  - 7 OUT: out_data<=A; out_valid=1 for one cycle
  - 8 HALT: -> HALT
  - 9 LDAM: A<=mem[arg]; Z updated
  - A LDBM: B<=mem[arg]
  - C STA: mem[arg]<=A
  - Any other value: err<=1 -> HALT
- Flags hold their value on instructions that do not update them. STA to an address that is fetched later takes effect on that later fetch (self-modifying code is allowed).
- start or load_en asserted while in FETCH/OPERAND/EXEC is ignored.
- halted stays high until leaving HALT. busy=0 in IDLE and HALT.

Test Plan:
- Load base 0x10 with words 01,05,02,03,03,00,07,00,08,00; start, start_pc=0x10 -> out_valid pulse with out_data=0x08, flag_c=0, flag_z=0; halted rises 15 cycles after start is sampled.
- Program LDA 02, LDB 03, SUB, HALT -> acc_a=0xFF, flag_c=1, flag_z=0. Then LDA 03, LDB 03, SUB -> acc_a=0x00, flag_z=1, flag_c=0.
- Loop: LDA 00, JZ to the HALT at address 0x20 -> PC jumps, intermediate OUT never pulses. STA 0x40 then LDBM 0x40 -> B equals the stored A.
- Load with base 0xFE and 4 data words -> memory at FE, FF, 00, 01 written; no write at 0x02.
- Opcode 0x0B at start_pc -> err=1 and halted=1 after 3 cycles; a new start clears err.
- rst=0 during EXEC of ADD -> next cycle acc_a=0, busy=0, state IDLE; previously loaded memory is retained (rerun gives the same result). Simultaneous load_en and start in IDLE -> enters load phase.
